// File: rtl/serial_tx_pkg.sv
// Shared types and sizing helpers for the serial word transmitter.
// Optional parity frame bit is enabled by defining SERIAL_TX_PARITY_EN.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } tx_state_t;

    // Bit-counter width for a count range of 0..limit-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/serial_word_transmitter_if.sv
// Load/serial bus of the serial word transmitter.
// master = word producer / serial consumer, slave = transmitter.
interface serial_word_transmitter_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic [WIDTH-1:0] par_in;
    logic             load_en;
    logic             ready;
    logic             ser_out;
    logic             ser_valid;
    logic             done;

    modport master (
        output par_in,
        output load_en,
        input  ready,
        input  ser_out,
        input  ser_valid,
        input  done
    );

    modport slave (
        input  par_in,
        input  load_en,
        output ready,
        output ser_out,
        output ser_valid,
        output done
    );

endinterface

// File: rtl/serial_word_transmitter_bit_counter.sv
// Clearable, enabled up-counter over 0..LIMIT-1 with a terminal-count flag.
module bit_counter
    import serial_tx_pkg::*;
#(
    parameter int unsigned LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CW = cnt_width(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    // Holds at LAST so the count can never wrap inside a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc_c) begin
            count <= count + CW'(1);
        end
    end

    assign tc_c = (count == LAST);

endmodule

// File: rtl/serial_word_transmitter.sv
// Parallel-in/serial-out word transmitter with load/ready handshake and done pulse.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit to every frame.
module serial_word_transmitter
    import serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    serial_word_transmitter_if.slave  bus
);

    tx_state_t        state;
    tx_state_t        state_d;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_d;
    logic             ready_d;
    logic             ser_out_d;
    logic             ser_valid_d;
    logic             done_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             last_bit_c;
`ifdef SERIAL_TX_PARITY_EN
    logic             par_q;
    logic             par_d;
`endif

    // The bit on the wire is always the head of the shift register.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    bit_counter #(
        .LIMIT (WIDTH)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .tc_c (last_bit_c)
    );

    // Next state, datapath updates and next registered outputs.
    always_comb begin
        state_d   = state;
        sreg_d    = sreg;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        ser_out_d = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d     = par_q;
`endif

        case (state)
            IDLE, DONE: begin
                if (bus.load_en && bus.ready) begin
                    state_d = SHIFT;
                    sreg_d  = bus.par_in;
                    cnt_clr = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = ^bus.par_in;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (last_bit_c) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_d = PAR;
`else
                    state_d = DONE;
`endif
                end else begin
                    cnt_en = 1'b1;
                    sreg_d = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                       : {1'b0, sreg[WIDTH-1:1]};
                end
            end
            PAR: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d     = (state_d == IDLE) || (state_d == DONE);
        ser_valid_d = (state_d == SHIFT) || (state_d == PAR);
        done_d      = (state_d == DONE);
        if (state_d == SHIFT) begin
            ser_out_d = head_bit(sreg_d);
        end
`ifdef SERIAL_TX_PARITY_EN
        else if (state_d == PAR) begin
            ser_out_d = par_d;
        end
`endif
    end

    // State, shift register and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            sreg          <= '0;
            bus.ready     <= 1'b1;
            bus.ser_out   <= 1'b0;
            bus.ser_valid <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state         <= state_d;
            sreg          <= sreg_d;
            bus.ready     <= ready_d;
            bus.ser_out   <= ser_out_d;
            bus.ser_valid <= ser_valid_d;
            bus.done      <= done_d;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    // Parity is fixed at the accept edge for the whole frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Self-checking bench: LSB-first and MSB-first transmitters driven in lockstep,
// checked against constant vector tables and a frame-stream reference model.
module tb_serial_word_transmitter;

    localparam int unsigned W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int unsigned FRAME = W + 1;
`else
    localparam int unsigned FRAME = W;
`endif

    localparam int E_GAP    = 0;
    localparam int E_BIT    = 1;
    localparam int E_PARITY = 2;
    localparam int E_END    = 3;

    typedef struct {
        int           kind;
        logic [W-1:0] w;
        int           idx;
    } ent_t;

    typedef struct {
        logic         le;
        logic [W-1:0] pi;
        logic         rdy;
        logic         vld;
        logic         bl;
        logic         bm;
        logic         dn;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_word_transmitter_if #(.WIDTH(W)) bus_l ();
    serial_word_transmitter_if #(.WIDTH(W)) bus_m ();

    serial_word_transmitter #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    serial_word_transmitter #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    ent_t cur;
    ent_t q[$];
    vec_t tbl[$];

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {ready,valid,ser_out,done}=%b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] obs_l();
        return {bus_l.ready, bus_l.ser_valid, bus_l.ser_out, bus_l.done};
    endfunction

    function automatic logic [3:0] obs_m();
        return {bus_m.ready, bus_m.ser_valid, bus_m.ser_out, bus_m.done};
    endfunction

    // Expected outputs for a stream token as seen by an LSB- or MSB-first link.
    function automatic logic [3:0] exp_of(input ent_t e, input bit msb);
        logic b;
        b = 1'b0;
        if (e.kind == E_BIT) b = msb ? e.w[W-1-e.idx] : e.w[e.idx];
        if (e.kind == E_PARITY) b = ^e.w;
        return {(e.kind == E_GAP) || (e.kind == E_END),
                (e.kind == E_BIT) || (e.kind == E_PARITY),
                b,
                e.kind == E_END};
    endfunction

    function automatic ent_t mk(input int kind, input logic [W-1:0] w, input int idx);
        ent_t e;
        e.kind = kind;
        e.w    = w;
        e.idx  = idx;
        return e;
    endfunction

    // Reference: an accepted word expands into its whole frame of per-cycle tokens.
    task automatic model_step(input logic le, input logic [W-1:0] pi);
        if (!rst) begin
            q.delete();
            cur = mk(E_GAP, '0, 0);
            return;
        end
        if ((cur.kind == E_GAP || cur.kind == E_END) && le) begin
            q.delete();
            for (int i = 0; i < int'(W); i++) q.push_back(mk(E_BIT, pi, i));
`ifdef SERIAL_TX_PARITY_EN
            q.push_back(mk(E_PARITY, pi, 0));
`endif
            q.push_back(mk(E_END, pi, 0));
        end
        if (q.size() > 0) cur = q.pop_front();
        else cur = mk(E_GAP, '0, 0);
    endtask

    task automatic drive(input logic le, input logic [W-1:0] pi);
        bus_l.load_en = le;
        bus_m.load_en = le;
        bus_l.par_in  = pi;
        bus_m.par_in  = pi;
    endtask

    // Called at a falling edge: drive, clock once, then check against the model.
    task automatic tick(input logic le, input logic [W-1:0] pi);
        drive(le, pi);
        @(posedge clk);
        model_step(le, pi);
        @(negedge clk);
        chk("model_lsb", obs_l(), exp_of(cur, 1'b0));
        chk("model_msb", obs_m(), exp_of(cur, 1'b1));
    endtask

    task automatic add(input logic le, input logic [W-1:0] pi, input logic rdy,
                       input logic vld, input logic bl, input logic bm, input logic dn);
        vec_t v;
        v.le = le; v.pi = pi; v.rdy = rdy; v.vld = vld; v.bl = bl; v.bm = bm; v.dn = dn;
        tbl.push_back(v);
    endtask

    initial begin
        cur = mk(E_GAP, '0, 0);
        drive(1'b1, 8'hFF);

        // Frame of 8'd17: LSB 1,0,0,0,1,0,0,0 / MSB 0,0,0,1,0,0,0,1, parity 0.
        add(1'b1, 8'd17, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef SERIAL_TX_PARITY_EN
        add(1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
        add(1'b0, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Frame of 8'h07: LSB 1,1,1,0,0,0,0,0 / MSB 0,0,0,0,0,1,1,1, parity 1.
        add(1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'hF8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'hF8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'hF8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 8'hF8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 8'hF8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'hF8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'hF8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef SERIAL_TX_PARITY_EN
        add(1'b0, 8'hF8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
`endif
        add(1'b0, 8'hF8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'hF8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset with a pending load request: nothing may start.
        #2 rst = 1'b0;
        #1;
        chk("reset_lsb", obs_l(), 4'b1000);
        chk("reset_msb", obs_m(), 4'b1000);
        @(negedge clk);
        tick(1'b1, 8'hFF);
        tick(1'b1, 8'hFF);
        rst = 1'b1;

        // Constant vector tables (first row is the first edge after release).
        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].le, tbl[i].pi);
            chk($sformatf("tbl%0d_lsb", i), obs_l(), {tbl[i].rdy, tbl[i].vld, tbl[i].bl, tbl[i].dn});
            chk($sformatf("tbl%0d_msb", i), obs_m(), {tbl[i].rdy, tbl[i].vld, tbl[i].bm, tbl[i].dn});
        end

        // Busy load ignored, then back-to-back accept in the done cycle.
        tick(1'b1, 8'hA5);
        for (int i = 0; i < int'(FRAME); i++) tick(1'b1, 8'h00);
        chk("b2b_done_lsb", obs_l(), 4'b1001);
        tick(1'b1, 8'h00);
        chk("b2b_first_zero_lsb", obs_l(), 4'b0100);
        for (int i = 0; i < int'(FRAME) + 2; i++) tick(1'b0, 8'hFF);

        // Asynchronous reset mid-frame after three bits.
        tick(1'b1, 8'hA5);
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        #2 rst = 1'b0;
        model_step(1'b0, 8'h00);
        #1;
        chk("midrst_lsb", obs_l(), 4'b1000);
        chk("midrst_msb", obs_m(), 4'b1000);
        @(negedge clk);
        tick(1'b1, 8'h3C);
        rst = 1'b1;
        tick(1'b1, 8'hA5);
        for (int i = 0; i < int'(FRAME) + 2; i++) tick(1'b0, W'($urandom));

        // Randomized traffic against the reference model.
        for (int i = 0; i < 500; i++) tick($urandom_range(0, 3) == 0, W'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_word_transmitter.md
Name: serial_word_transmitter

Overview:
Parallel-in/serial-out transmitter, the unloading side of the team's 8-bit load-enabled register.
- Accepts one WIDTH-bit word through a load/ready handshake.
- Shifts the word out one bit per clock with a frame-valid qualifier, then pulses done.
- Moves data-point words from the regression datapath onto a 1-bit link or debug port. The matching receiver deserializes it back into a register.

Parameters:
WIDTH, 8, word width in bits (>= 2)
MSB_FIRST, 0, 0 = LSB shifted first, 1 = MSB shifted first

Ports:
clk  input  1  single system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (rst = 0 resets immediately, independent of clk)
par_in  input  WIDTH  word to transmit, sampled only on an accepted load
load_en  input  1  load request, qualifies par_in
ready  output  1  block can accept a word this cycle
ser_out  output  1  serial data bit
ser_valid  output  1  ser_out carries a frame bit this cycle
done  output  1  one-cycle pulse after the last frame bit

Behaviour:
- Reset values while rst = 0: state IDLE, ready = 1, ser_out = 0, ser_valid = 0, done = 0, shift register = 0, bit counter = 0.
- States:
  - IDLE: ready = 1, ser_valid = 0.
  - SHIFT: ready = 0, ser_valid = 1.
  - PAR: parity state, only with the optional feature. ready = 0, ser_valid = 1.
  - DONE: done = 1, ready = 1, ser_valid = 0, ser_out = 0.
- Accept: a load is accepted when load_en & ready at a rising edge.
  - par_in is captured into the shift register.
  - Counter is cleared.
  - Next state is SHIFT.
  - load_en with ready = 0 is ignored; no queuing and no error.
- Latency: accept at edge k, so the first bit is on ser_out during cycle k+1.
  - Bit i appears during cycle k+1+i, for i = 0..WIDTH-1.
  - Bit order is par_in[i] (MSB_FIRST = 0) or par_in[WIDTH-1-i] (MSB_FIRST = 1).
- SHIFT: shift register and counter advance each edge. When the counter reaches WIDTH-1:
  - next state is PAR if the feature is enabled, otherwise DONE.
- DONE lasts exactly one cycle. Next state:
  - SHIFT if load_en is asserted that cycle (back-to-back frames with a 1-cycle gap);
  - IDLE otherwise.
- par_in changes after the accept edge have no effect on the frame in flight.
- ser_out is registered; it holds 0 whenever ser_valid = 0.
- Reset mid-frame: the frame is abandoned with no done pulse, and all outputs go to reset values asynchronously.
- After reset release, the first edge with load_en = 1 is accepted.
- Bit counter width is $clog2(WIDTH); it never exceeds WIDTH-1 and never wraps within a frame.

Optional Feature:
Macro: SERIAL_TX_PARITY_EN
- Defined:
  - After the WIDTH data bits, one PAR cycle drives the even-parity bit (XOR of the captured word) with ser_valid = 1.
  - The parity bit is computed at the accept edge and stored.
  - Frame length is WIDTH+1 and done moves one cycle later.
- Undefined: no PAR state and no parity register; frame length is WIDTH.

Decomposition:
- Shared package serial_tx_pkg holds:
  - state typedef tx_state_t with encodings IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, DONE = 2'd3;
  - localparam function for counter width.
- One natural sub-module: bit_counter. It is a clearable up-counter with enable and a terminal-count output (count == LIMIT-1).

Test Plan:
1. Reset: hold rst = 0 for 2 cycles with load_en = 1 and par_in = 8'hFF -> ready = 1, ser_valid = 0, ser_out = 0, done = 0 throughout; no frame starts.
2. Basic frame: WIDTH = 8, MSB_FIRST = 0, par_in = 8'd17 with load_en pulsed for 1 cycle -> ser_valid high for 8 cycles with ser_out 1,0,0,0,1,0,0,0; done high in the following single cycle; ready = 0 during the frame.
3. Busy and back-to-back: accept 8'hA5, change par_in to 8'h00 and hold load_en = 1 through the frame -> bits 1,0,1,0,0,1,0,1; the second word 8'h00 is accepted in the DONE cycle; its 8 zero bits start exactly one cycle after done.
4. Bit order: MSB_FIRST = 1 with par_in = 8'h07 -> ser_out 0,0,0,0,0,1,1,1.
5. Reset mid-frame: assert rst = 0 asynchronously (between edges) after 3 bits of 8'hA5 -> ser_valid and ser_out drop immediately; no done pulse; a new load after release sends a full frame.
6. Parity (SERIAL_TX_PARITY_EN defined):
   - 8'h07 -> 8 data bits then parity bit 1, done in cycle 10 after accept;
   - 8'd17 -> parity bit 0.
